proc_dpath_gen: RTL and testbench
=================================

PROC_DPATH_GEN -- requirements
Module: proc_dpath_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/register width.
REQ-002 SHALL have parameter MUL_ITER, default 1: 0 = single-cycle multiplier, 1 = iterative early-terminating multiplier.
REQ-003 SHALL have parameter RST_PC, default 32'h00000200, PC value after reset.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have ports: rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: imemreq_addr  out  XLEN  fetch address (current PC).
REQ-007 SHALL have ports: imemresp_data  in  32  fetched instruction.
REQ-008 SHALL have ports: dmemreq_addr  out  XLEN  M-stage address (X/M result).
REQ-009 SHALL have ports: dmemreq_wdata  out  XLEN  M-stage store data.
REQ-010 SHALL have ports: dmemresp_rdata  in  XLEN  load data.
REQ-011 SHALL have ports: c2d_reg_en_F / c2d_reg_en_D / c2d_reg_en_X  in  1 each  PC, F/D, D/X register enables.
REQ-012 SHALL have ports: c2d_pc_sel_F  in  2  next-PC select.
REQ-013 SHALL have ports: c2d_imm_type_D  in  2  immediate format (0 I, 1 S, 2 J, 3 B).
REQ-014 SHALL have ports: c2d_op1_byp_sel_D, c2d_op2_byp_sel_D  in  2 each  operand bypass select.
REQ-015 SHALL have ports: c2d_op1_sel_D  in  1; c2d_op2_sel_D  in  2  operand select.
REQ-016 SHALL have ports: c2d_alu_fn_X  in  1 (0 add, 1 eq); c2d_result_sel_X  in  1 (0 ALU, 1 multiplier).
REQ-017 SHALL have ports: c2d_mul_start_X  in  1  launch iterative multiply on D/X operands.
REQ-018 SHALL have ports: c2d_wb_sel_M  in  1 (0 X/M result, 1 dmemresp_rdata).
REQ-019 SHALL have ports: c2d_rf_wen_W  in  1; c2d_rf_waddr_W  in  5  register-file write.
REQ-020 SHALL have ports: d2c_eq_X  out  1; d2c_mul_busy_X  out  1; d2c_inst  out  32  F/D instruction.
REQ-021 SHALL have ports: trace_data  out  XLEN  register-file write data.

Function
REQ-022 SHALL implement five stages F/D/X/M/W; PC, F/D (inst, inst_pc) and D/X (op1, op2, store data) registers update only when their enable is 1; X/M and M/W update every cycle.
REQ-023 SHALL select next PC: 0 PC+4, 1 op1 bypass value, 2 inst_pc+imm, 3 RST_PC.
REQ-024 SHALL select bypass: 0 regfile, 1 X result (pre-register), 2 M result (pre-register), 3 W data; op1: 0 bypass, 1 inst_pc; op2: 0 bypass, 1 imm, 2 constant 4, 3 zero.
REQ-025 SHALL feed store data from op2 bypass through D/X and X/M registers.
REQ-026 SHALL sign-extend immediates to XLEN; all arithmetic modulo 2^XLEN, product = low XLEN bits.
REQ-027 SHALL produce ALU eq output {0...,op1==op2}; d2c_eq_X = ALU bit 0.
REQ-028 SHALL read x0 as zero, ignore writes to x0, write on rising edge when c2d_rf_wen_W=1; same-cycle read returns old value.
REQ-029 SHALL (MUL_ITER=1) run FSM IDLE->BUSY on c2d_mul_start_X in IDLE, latching op1/op2, clearing accumulator.
REQ-030 SHALL in BUSY per cycle add multiplicand if multiplier LSB=1, shift multiplicand left, multiplier right; go DONE when shifted multiplier becomes zero, so BUSY lasts max(1, index of highest set bit of op2 + 1) cycles.
REQ-031 SHALL assert d2c_mul_busy_X only in BUSY; DONE holds product one cycle then returns to IDLE (or BUSY if start); start while BUSY ignored.
REQ-032 SHALL (MUL_ITER=0) output combinational product with d2c_mul_busy_X tied 0.

Reset
REQ-033 SHALL on rst=0 immediately: PC=RST_PC, all pipeline registers 0, FSM IDLE, busy 0, accumulator 0 (aborting any multiply); regfile contents not reset.

Verification
REQ-034 Release reset, RST_PC=0x200, reg_en_F=1, pc_sel=0 -> imemreq_addr 0x200 then 0x204.
REQ-035 addi x1,x0,5 then add x2,x1,x1 with both byp_sel=1 -> trace_data 10 in W, x2=10.
REQ-036 Start multiply 7*6 -> busy 3 cycles, DONE result_sel=1 yields 42.
REQ-037 Start 0xFFFFFFFF*0xFFFFFFFF -> busy 32 cycles, result 0x00000001; op2=0 -> busy 1 cycle, result 0.
REQ-038 Assert rst mid-BUSY -> busy 0 same cycle, following start 3*3 yields 9.
REQ-039 inst_pc 0x100, J-imm 0x20, pc_sel=2 -> next PC 0x120; rf write to x0 of 0x55 -> x0 reads 0.

Source files
------------

// File: rtl/proc_dpath_gen.sv
// Five-stage (F/D/X/M/W) processor datapath with operand bypassing, a 2-read/1-write
// register file and a selectable single-cycle or early-terminating iterative multiplier.
module proc_dpath_gen #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_ITER = 1,
  parameter logic [31:0] RST_PC   = 32'h00000200
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imemreq_addr,
  input  logic [31:0]     imemresp_data,
  output logic [XLEN-1:0] dmemreq_addr,
  output logic [XLEN-1:0] dmemreq_wdata,
  input  logic [XLEN-1:0] dmemresp_rdata,
  input  logic            c2d_reg_en_F,
  input  logic            c2d_reg_en_D,
  input  logic            c2d_reg_en_X,
  input  logic [1:0]      c2d_pc_sel_F,
  input  logic [1:0]      c2d_imm_type_D,
  input  logic [1:0]      c2d_op1_byp_sel_D,
  input  logic [1:0]      c2d_op2_byp_sel_D,
  input  logic            c2d_op1_sel_D,
  input  logic [1:0]      c2d_op2_sel_D,
  input  logic            c2d_alu_fn_X,
  input  logic            c2d_result_sel_X,
  input  logic            c2d_mul_start_X,
  input  logic            c2d_wb_sel_M,
  input  logic            c2d_rf_wen_W,
  input  logic [4:0]      c2d_rf_waddr_W,
  output logic            d2c_eq_X,
  output logic            d2c_mul_busy_X,
  output logic [31:0]     d2c_inst,
  output logic [XLEN-1:0] trace_data
);

  localparam logic [XLEN-1:0] RST_PC_V = XLEN'(RST_PC);
  localparam logic [XLEN-1:0] FOUR_V   = XLEN'(32'd4);

  // Immediate formats: 0 I, 1 S, 2 J, 3 B; all sign-extended from instruction bit 31.
  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] inst, input logic [1:0] sel);
    logic [31:0] imm32;
    case (sel)
      2'd0:    imm32 = {{20{inst[31]}}, inst[31:20]};
      2'd1:    imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      2'd2:    imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      2'd3:    imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      default: imm32 = 32'd0;
    endcase
    return XLEN'($signed(imm32));
  endfunction

  logic [XLEN-1:0] pc_r;
  logic [31:0]     inst_d_r;
  logic [XLEN-1:0] inst_pc_d_r;
  logic [XLEN-1:0] op1_x_r;
  logic [XLEN-1:0] op2_x_r;
  logic [XLEN-1:0] sd_x_r;
  logic [XLEN-1:0] result_m_r;
  logic [XLEN-1:0] sd_m_r;
  logic [XLEN-1:0] wb_data_w_r;
  logic [XLEN-1:0] rf_r [32];

  logic [4:0]      rs1_s;
  logic [4:0]      rs2_s;
  logic [XLEN-1:0] rf_rdata1_s;
  logic [XLEN-1:0] rf_rdata2_s;
  logic [XLEN-1:0] imm_d_s;
  logic [XLEN-1:0] byp1_s;
  logic [XLEN-1:0] byp2_s;
  logic [XLEN-1:0] op1_d_s;
  logic [XLEN-1:0] op2_d_s;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] alu_out_s;
  logic [XLEN-1:0] mul_out_s;
  logic            mul_busy_s;
  logic [XLEN-1:0] result_x_s;
  logic [XLEN-1:0] wb_data_m_s;

  assign rs1_s       = inst_d_r[19:15];
  assign rs2_s       = inst_d_r[24:20];
  assign rf_rdata1_s = (rs1_s == 5'd0) ? '0 : rf_r[rs1_s];
  assign rf_rdata2_s = (rs2_s == 5'd0) ? '0 : rf_r[rs2_s];
  assign imm_d_s     = imm_gen(inst_d_r, c2d_imm_type_D);

  // Operand bypass muxes and operand selection in D.
  always_comb begin
    byp1_s  = rf_rdata1_s;
    byp2_s  = rf_rdata2_s;
    op1_d_s = byp1_s;
    op2_d_s = byp2_s;
    case (c2d_op1_byp_sel_D)
      2'd0:    byp1_s = rf_rdata1_s;
      2'd1:    byp1_s = result_x_s;
      2'd2:    byp1_s = wb_data_m_s;
      2'd3:    byp1_s = wb_data_w_r;
      default: byp1_s = rf_rdata1_s;
    endcase
    case (c2d_op2_byp_sel_D)
      2'd0:    byp2_s = rf_rdata2_s;
      2'd1:    byp2_s = result_x_s;
      2'd2:    byp2_s = wb_data_m_s;
      2'd3:    byp2_s = wb_data_w_r;
      default: byp2_s = rf_rdata2_s;
    endcase
    if (c2d_op1_sel_D) begin
      op1_d_s = inst_pc_d_r;
    end else begin
      op1_d_s = byp1_s;
    end
    case (c2d_op2_sel_D)
      2'd0:    op2_d_s = byp2_s;
      2'd1:    op2_d_s = imm_d_s;
      2'd2:    op2_d_s = FOUR_V;
      2'd3:    op2_d_s = '0;
      default: op2_d_s = '0;
    endcase
  end

  // Next-PC selection.
  always_comb begin
    pc_next_s = pc_r + FOUR_V;
    case (c2d_pc_sel_F)
      2'd0:    pc_next_s = pc_r + FOUR_V;
      2'd1:    pc_next_s = byp1_s;
      2'd2:    pc_next_s = inst_pc_d_r + imm_d_s;
      2'd3:    pc_next_s = RST_PC_V;
      default: pc_next_s = RST_PC_V;
    endcase
  end

  // ALU, X result select and M writeback select.
  always_comb begin
    alu_out_s   = op1_x_r + op2_x_r;
    result_x_s  = alu_out_s;
    wb_data_m_s = result_m_r;
    if (c2d_alu_fn_X) begin
      alu_out_s = {{(XLEN-1){1'b0}}, (op1_x_r == op2_x_r)};
    end else begin
      alu_out_s = op1_x_r + op2_x_r;
    end
    if (c2d_result_sel_X) begin
      result_x_s = mul_out_s;
    end else begin
      result_x_s = alu_out_s;
    end
    if (c2d_wb_sel_M) begin
      wb_data_m_s = dmemresp_rdata;
    end else begin
      wb_data_m_s = result_m_r;
    end
  end

  // Enabled PC, F/D and D/X registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r        <= RST_PC_V;
      inst_d_r    <= 32'd0;
      inst_pc_d_r <= '0;
      op1_x_r     <= '0;
      op2_x_r     <= '0;
      sd_x_r      <= '0;
    end else begin
      if (c2d_reg_en_F) begin
        pc_r <= pc_next_s;
      end
      if (c2d_reg_en_D) begin
        inst_d_r    <= imemresp_data;
        inst_pc_d_r <= pc_r;
      end
      if (c2d_reg_en_X) begin
        op1_x_r <= op1_d_s;
        op2_x_r <= op2_d_s;
        sd_x_r  <= byp2_s;
      end
    end
  end

  // Free-running X/M and M/W registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_m_r  <= '0;
      sd_m_r      <= '0;
      wb_data_w_r <= '0;
    end else begin
      result_m_r  <= result_x_s;
      sd_m_r      <= sd_x_r;
      wb_data_w_r <= wb_data_m_m_sel();
    end
  end

  function automatic logic [XLEN-1:0] wb_data_m_m_sel();
    return wb_data_m_s;
  endfunction

  // Register file write port; contents intentionally survive reset, x0 is never written.
  always_ff @(posedge clk) begin
    if (c2d_rf_wen_W && (c2d_rf_waddr_W != 5'd0)) begin
      rf_r[c2d_rf_waddr_W] <= wb_data_w_r;
    end
  end

  generate
    if (MUL_ITER != 0) begin : g_mul_iter
      typedef enum logic [1:0] {MUL_IDLE = 2'd0, MUL_BUSY = 2'd1, MUL_DONE = 2'd2} mul_state_e;
      mul_state_e      state_r;
      mul_state_e      state_nxt_s;
      logic [XLEN-1:0] mcand_r;
      logic [XLEN-1:0] mplier_r;
      logic [XLEN-1:0] acc_r;
      logic [XLEN-1:0] mplier_shift_s;

      assign mplier_shift_s = {1'b0, mplier_r[XLEN-1:1]};

      // Multiplier state register.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_r <= MUL_IDLE;
        end else begin
          state_r <= state_nxt_s;
        end
      end

      // Next state: BUSY ends once no set multiplier bits remain after this step.
      always_comb begin
        state_nxt_s = state_r;
        case (state_r)
          MUL_IDLE, MUL_DONE: begin
            if (c2d_mul_start_X) begin
              state_nxt_s = MUL_BUSY;
            end else begin
              state_nxt_s = MUL_IDLE;
            end
          end
          MUL_BUSY: begin
            if (mplier_shift_s == '0) begin
              state_nxt_s = MUL_DONE;
            end else begin
              state_nxt_s = MUL_BUSY;
            end
          end
          default: state_nxt_s = MUL_IDLE;
        endcase
      end

      // Shift-and-add datapath.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          mcand_r  <= '0;
          mplier_r <= '0;
          acc_r    <= '0;
        end else begin
          case (state_r)
            MUL_IDLE, MUL_DONE: begin
              if (c2d_mul_start_X) begin
                mcand_r  <= op1_x_r;
                mplier_r <= op2_x_r;
                acc_r    <= '0;
              end
            end
            MUL_BUSY: begin
              if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
              end
              mcand_r  <= {mcand_r[XLEN-2:0], 1'b0};
              mplier_r <= mplier_shift_s;
            end
            default: begin
              acc_r <= '0;
            end
          endcase
        end
      end

      assign mul_out_s  = acc_r;
      assign mul_busy_s = (state_r == MUL_BUSY);
    end else begin : g_mul_comb
      assign mul_out_s  = op1_x_r * op2_x_r;
      assign mul_busy_s = 1'b0;
    end
  endgenerate

  assign imemreq_addr   = pc_r;
  assign dmemreq_addr   = result_m_r;
  assign dmemreq_wdata  = sd_m_r;
  assign d2c_inst       = inst_d_r;
  assign trace_data     = wb_data_w_r;
  assign d2c_eq_X       = alu_out_s[0];
  assign d2c_mul_busy_X = mul_busy_s;

endmodule

// File: tb/tb_proc_dpath_gen.sv
// Directed bench for proc_dpath_gen: immediate/operand vector table plus hand-written
// pipeline, bypass, PC-redirect and multiplier sequences.
module tb_proc_dpath_gen;

  logic        clk;
  logic        rst;
  logic [31:0] imemreq_addr;
  logic [31:0] imemresp_data;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic [31:0] dmemresp_rdata;
  logic        en_f, en_d, en_x;
  logic [1:0]  pc_sel, imm_type, byp1, byp2, op2_sel;
  logic        op1_sel, alu_fn, result_sel, mul_start, wb_sel, rf_wen;
  logic [4:0]  rf_waddr;
  logic        eq_x, mul_busy;
  logic [31:0] inst_d;
  logic [31:0] trace_data;

  int n_cmp = 0;
  int n_bad = 0;

  proc_dpath_gen #(.XLEN(32), .MUL_ITER(1), .RST_PC(32'h00000200)) dut (
    .clk(clk), .rst(rst),
    .imemreq_addr(imemreq_addr), .imemresp_data(imemresp_data),
    .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(dmemresp_rdata),
    .c2d_reg_en_F(en_f), .c2d_reg_en_D(en_d), .c2d_reg_en_X(en_x),
    .c2d_pc_sel_F(pc_sel), .c2d_imm_type_D(imm_type),
    .c2d_op1_byp_sel_D(byp1), .c2d_op2_byp_sel_D(byp2),
    .c2d_op1_sel_D(op1_sel), .c2d_op2_sel_D(op2_sel),
    .c2d_alu_fn_X(alu_fn), .c2d_result_sel_X(result_sel), .c2d_mul_start_X(mul_start),
    .c2d_wb_sel_M(wb_sel), .c2d_rf_wen_W(rf_wen), .c2d_rf_waddr_W(rf_waddr),
    .d2c_eq_X(eq_x), .d2c_mul_busy_X(mul_busy), .d2c_inst(inst_d), .trace_data(trace_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [1:0]  imm_type;
    logic        op1_sel;
    logic [1:0]  op2_sel;
    logic        alu_fn;
    logic [31:0] exp_res;
    logic        exp_eq;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl();
    en_f = 1'b0; en_d = 1'b0; en_x = 1'b0;
    pc_sel = 2'd0; imm_type = 2'd0; byp1 = 2'd0; byp2 = 2'd0;
    op1_sel = 1'b0; op2_sel = 2'd0; alu_fn = 1'b0; result_sel = 1'b0;
    mul_start = 1'b0; wb_sel = 1'b0; rf_wen = 1'b0; rf_waddr = 5'd0;
  endtask

  task automatic do_reset();
    idle_ctl();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Put a onto the M-stage value and b into W, then latch them into D/X as op1/op2.
  task automatic mul_load(input logic [31:0] a, input logic [31:0] b);
    dmemresp_rdata = b; wb_sel = 1'b1;
    step();
    dmemresp_rdata = a; byp1 = 2'd2; byp2 = 2'd3; op1_sel = 1'b0; op2_sel = 2'd0; en_x = 1'b1;
    step();
    en_x = 1'b0; wb_sel = 1'b0; byp1 = 2'd0; byp2 = 2'd0;
  endtask

  task automatic mul_run(input string name, input logic [31:0] a, input logic [31:0] b,
                         input int exp_busy, input logic [31:0] exp_p, input bit poke);
    int cnt;
    mul_load(a, b);
    mul_start = 1'b1;
    step();
    mul_start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 64 && mul_busy; i++) begin
      cnt++;
      mul_start = (poke && cnt == 1) ? 1'b1 : 1'b0;
      step();
    end
    mul_start = 1'b0;
    check({name, "_busy_cycles"}, cnt, exp_busy);
    result_sel = 1'b1;
    step();
    result_sel = 1'b0;
    check({name, "_product"}, dmemreq_addr, exp_p);
  endtask

  initial begin
    vec_t vec [18];
    vec[0]  = '{32'h00500093, 2'd0, 1'b1, 2'd1, 1'b0, 32'h00000205, 1'b1};
    vec[1]  = '{32'hFFF00093, 2'd0, 1'b1, 2'd1, 1'b0, 32'h000001FF, 1'b1};
    vec[2]  = '{32'h02000200, 2'd1, 1'b1, 2'd1, 1'b0, 32'h00000224, 1'b0};
    vec[3]  = '{32'hFE000F80, 2'd1, 1'b1, 2'd1, 1'b0, 32'h000001FF, 1'b1};
    vec[4]  = '{32'h02000000, 2'd2, 1'b1, 2'd1, 1'b0, 32'h00000220, 1'b0};
    vec[5]  = '{32'h80000000, 2'd2, 1'b1, 2'd1, 1'b0, 32'hFFF00200, 1'b0};
    vec[6]  = '{32'h00001000, 2'd2, 1'b1, 2'd1, 1'b0, 32'h00001200, 1'b0};
    vec[7]  = '{32'h00100000, 2'd2, 1'b1, 2'd1, 1'b0, 32'h00000A00, 1'b0};
    vec[8]  = '{32'h00000080, 2'd3, 1'b1, 2'd1, 1'b0, 32'h00000A00, 1'b0};
    vec[9]  = '{32'h00000F00, 2'd3, 1'b1, 2'd1, 1'b0, 32'h0000021E, 1'b0};
    vec[10] = '{32'h80000000, 2'd3, 1'b1, 2'd1, 1'b0, 32'hFFFFF200, 1'b0};
    vec[11] = '{32'h7E000000, 2'd3, 1'b1, 2'd1, 1'b0, 32'h000009E0, 1'b0};
    vec[12] = '{32'h00000000, 2'd0, 1'b1, 2'd2, 1'b0, 32'h00000204, 1'b0};
    vec[13] = '{32'h00000000, 2'd0, 1'b1, 2'd3, 1'b0, 32'h00000200, 1'b0};
    vec[14] = '{32'h20000000, 2'd0, 1'b1, 2'd1, 1'b1, 32'h00000001, 1'b1};
    vec[15] = '{32'h20100000, 2'd0, 1'b1, 2'd1, 1'b1, 32'h00000000, 1'b0};
    vec[16] = '{32'h00500093, 2'd0, 1'b0, 2'd1, 1'b0, 32'h00000005, 1'b1};
    vec[17] = '{32'h80000000, 2'd0, 1'b0, 2'd1, 1'b0, 32'hFFFFF800, 1'b0};

    idle_ctl();
    imemresp_data = 32'd0;
    dmemresp_rdata = 32'd0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    step();
    check("rst_pc", imemreq_addr, 32'h00000200);
    check("rst_dmem_addr", dmemreq_addr, 32'd0);
    check("rst_dmem_wdata", dmemreq_wdata, 32'd0);
    check("rst_trace", trace_data, 32'd0);
    check("rst_inst", inst_d, 32'd0);
    check("rst_busy", mul_busy, 32'd0);
    rst = 1'b1;
    step();

    // Immediate/operand vectors; PC is held at 0x200 so inst_pc is 0x200.
    for (int i = 0; i < 18; i++) begin
      imemresp_data = vec[i].inst; en_d = 1'b1;
      step();
      en_d = 1'b0;
      imm_type = vec[i].imm_type; op1_sel = vec[i].op1_sel; op2_sel = vec[i].op2_sel;
      byp1 = 2'd0; byp2 = 2'd0; en_x = 1'b1;
      step();
      en_x = 1'b0;
      alu_fn = vec[i].alu_fn; result_sel = 1'b0;
      #1;
      check($sformatf("vec%0d_eq", i), eq_x, vec[i].exp_eq);
      step();
      check($sformatf("vec%0d_result", i), dmemreq_addr, vec[i].exp_res);
      alu_fn = 1'b0;
    end

    // Sequential fetch.
    check("fetch_pc0", imemreq_addr, 32'h00000200);
    en_f = 1'b1; pc_sel = 2'd0;
    step();
    check("fetch_pc1", imemreq_addr, 32'h00000204);
    step();
    check("fetch_pc2", imemreq_addr, 32'h00000208);
    en_f = 1'b0;

    // addi x1,x0,5 ; add x2,x1,x1 with X bypass, then read x2 back through the regfile.
    do_reset();
    imemresp_data = 32'h00500093; en_d = 1'b1;
    step();
    imemresp_data = 32'h00108133; imm_type = 2'd0; op1_sel = 1'b0; byp1 = 2'd0; op2_sel = 2'd1; en_x = 1'b1;
    step();
    imemresp_data = 32'h00010013; byp1 = 2'd1; byp2 = 2'd1; op2_sel = 2'd0;
    step();
    en_d = 1'b0; en_x = 1'b0; byp1 = 2'd0; byp2 = 2'd0;
    check("addi_xm", dmemreq_addr, 32'd5);
    step();
    check("addi_w", trace_data, 32'd5);
    rf_wen = 1'b1; rf_waddr = 5'd1;
    step();
    check("add_w", trace_data, 32'd10);
    rf_waddr = 5'd2;
    step();
    rf_wen = 1'b0; op1_sel = 1'b0; byp1 = 2'd0; op2_sel = 2'd2; en_x = 1'b1;
    step();
    en_x = 1'b0; op2_sel = 2'd0;
    step();
    check("x2_read_plus4", dmemreq_addr, 32'd14);

    // Write 0x55 to x0 and read x0 back; then M and W bypass paths.
    dmemresp_rdata = 32'h55; wb_sel = 1'b1;
    step();
    check("wb_load_trace", trace_data, 32'h55);
    rf_wen = 1'b1; rf_waddr = 5'd0; imemresp_data = 32'h00000013; en_d = 1'b1;
    step();
    rf_wen = 1'b0; en_d = 1'b0; wb_sel = 1'b0; byp1 = 2'd0; op1_sel = 1'b0; op2_sel = 2'd3; en_x = 1'b1;
    step();
    en_x = 1'b0;
    step();
    check("x0_read", dmemreq_addr, 32'd0);
    dmemresp_rdata = 32'h77; wb_sel = 1'b1; byp1 = 2'd2; op2_sel = 2'd3; en_x = 1'b1;
    step();
    en_x = 1'b0; byp1 = 2'd0; wb_sel = 1'b0;
    step();
    check("byp_m", dmemreq_addr, 32'h77);
    dmemresp_rdata = 32'h99; wb_sel = 1'b1;
    step();
    dmemresp_rdata = 32'h11; byp1 = 2'd3; en_x = 1'b1;
    step();
    en_x = 1'b0; byp1 = 2'd0; wb_sel = 1'b0;
    step();
    check("byp_w", dmemreq_addr, 32'h99);

    // Redirect PC to 0x100, fetch a J-type with imm 0x20, jump to 0x120, then back to reset PC.
    dmemresp_rdata = 32'h100; wb_sel = 1'b1;
    step();
    wb_sel = 1'b0; byp1 = 2'd3; pc_sel = 2'd1; en_f = 1'b1;
    step();
    check("pc_byp", imemreq_addr, 32'h100);
    byp1 = 2'd0; en_f = 1'b0; pc_sel = 2'd0; imemresp_data = 32'h02000000; en_d = 1'b1;
    step();
    en_d = 1'b0;
    check("inst_fd", inst_d, 32'h02000000);
    imm_type = 2'd2; pc_sel = 2'd2; en_f = 1'b1;
    step();
    check("pc_jump", imemreq_addr, 32'h120);
    pc_sel = 2'd3;
    step();
    check("pc_rst_sel", imemreq_addr, 32'h200);
    en_f = 1'b0; pc_sel = 2'd0; imm_type = 2'd0;

    // Iterative multiplier.
    mul_run("mul_7x6", 32'd7, 32'd6, 3, 32'd42, 1'b1);
    mul_run("mul_ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'h00000001, 1'b0);
    mul_run("mul_5x0", 32'd5, 32'd0, 1, 32'd0, 1'b0);
    mul_run("mul_shift16", 32'h12345678, 32'h10, 5, 32'h23456780, 1'b0);

    // Reset in the middle of a long multiply.
    mul_load(32'hFFFFFFFF, 32'hFFFFFFFF);
    mul_start = 1'b1;
    step();
    mul_start = 1'b0;
    step();
    step();
    check("abort_busy_before", mul_busy, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy_now", mul_busy, 32'd0);
    check("abort_pc", imemreq_addr, 32'h200);
    step();
    rst = 1'b1;
    idle_ctl();
    mul_run("mul_3x3", 32'd3, 32'd3, 2, 32'd9, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
